// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the core: word RAM, MMIO page (TX FIFO,
// STATUS, CYCLE), and sticky error reporting for bad accesses.
module riscv_dmem_responder #(
  parameter int          RAM_AW    = 10,
  parameter int          FIFO_AW   = 3,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        err_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [31:0] mem [0:(2**RAM_AW)-1];
  logic [7:0]  fifo [0:DEPTH-1];

  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [31:0]        cyc_q;
  logic               err_q, ovf_q;

  // request decode
  logic load, store, aligned, is_mmio, is_ram, acc_ok, mmio_ok, acc_err;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       off;
  assign load    = data_ce_i & ~data_we_i;
  assign store   = data_ce_i & data_we_i;
  assign aligned = (data_addr_i[1:0] == 2'b00);
  assign is_mmio = (data_addr_i[31:16] == MMIO_BASE[31:16]);
  // RAM depth is a power of two, so "addr < 4*2^RAM_AW" is "upper bits zero"
  assign is_ram  = ~is_mmio & (data_addr_i[31:RAM_AW+2] == '0);
  assign ram_idx = data_addr_i[RAM_AW+1:2];
  assign off     = data_addr_i[15:0];
  assign acc_ok  = data_ce_i & aligned;
  assign mmio_ok = acc_ok & is_mmio;
  assign acc_err = data_ce_i & (~aligned | (~is_mmio & ~is_ram));

  // FIFO control; a pop frees the slot a same-cycle push needs when full
  logic full, empty, push, pop, push_acc, ovf_set, err_clr, ovf_clr;
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push     = store & mmio_ok & (off == 16'h0000);
  assign pop      = tx_valid_o & tx_ready_i;
  assign push_acc = push & (~full | pop);
  assign ovf_set  = push & full & ~pop;
  assign err_clr  = store & mmio_ok & (off == 16'h0004) & data_i[2];
  assign ovf_clr  = store & mmio_ok & (off == 16'h0004) & data_i[3];

  assign tx_valid_o = ~empty;
  assign tx_data_o  = empty ? 8'h00 : fifo[rd_ptr];
  assign err_o      = err_q;

  // zero-latency load mux; anything but a valid aligned load reads as 0
  always_comb begin
    data_o = 32'h0;
    if (load & aligned) begin
      if (is_ram) data_o = mem[ram_idx];
      else if (is_mmio) begin
        case (off)
          16'h0004: data_o = {28'h0, ovf_q, err_q, full, empty};
          16'h0008: data_o = cyc_q;
          default:  data_o = 32'h0;
        endcase
      end
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (store & acc_ok & is_ram) mem[ram_idx] <= data_i;
  end

  // FIFO storage; only the pointers/count are reset
  always_ff @(posedge clk) begin
    if (push_acc) fifo[wr_ptr] <= data_i[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_acc, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      err_q <= (err_q & ~err_clr) | acc_err;
      ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
    end
  end

  // free-running cycle counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= 32'h0;
    else     cyc_q <= cyc_q + 32'd1;
  end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
module tb_riscv_dmem_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ce = 1'b0, we = 1'b0, rdy = 1'b0;
  logic [31:0] addr = '0, din = '0;
  logic [31:0] data_o;
  logic        tx_valid_o, err_o;
  logic [7:0]  tx_data_o;

  riscv_dmem_responder dut (
    .clk(clk), .rst(rst), .data_ce_i(ce), .data_we_i(we),
    .data_addr_i(addr), .data_i(din), .data_o(data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(rdy), .tx_data_o(tx_data_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference model state
  logic [31:0] m_mem [1024];
  bit          m_known [1024];
  logic [7:0]  q[$];
  bit          m_err, m_ovf;
  logic [31:0] m_cnt;

  logic [31:0] last_rd;
  logic        last_txv, last_err;
  logic [7:0]  last_txd;

  localparam logic [31:0] TXD = 32'hFFFF_0000, STS = 32'hFFFF_0004, CYC = 32'hFFFF_0008;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {28'h0, m_ovf, m_err, q.size() == 8, q.size() == 0};
  endfunction

  task automatic m_reset();
    q.delete();
    m_err = 0;
    m_ovf = 0;
    m_cnt = 0;
  endtask

  // drive one request at a negedge, check outputs vs model, advance model
  task automatic do_cycle(input logic c, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic r);
    bit mm, rm, al, known, set, pop, push, clr_e, clr_o, ovf_set;
    logic [31:0] exp;
    ce = c; we = w; addr = a; din = d; rdy = r;
    #1;
    last_rd = data_o; last_txv = tx_valid_o; last_txd = tx_data_o; last_err = err_o;
    mm = (a[31:16] == 16'hFFFF);
    rm = !mm && (a < 32'h1000);
    al = (a[1:0] == 2'b00);
    exp = 0; known = 1;
    if (c && !w && al) begin
      if (rm) begin
        if (m_known[a[11:2]]) exp = m_mem[a[11:2]];
        else known = 0;
      end else if (mm) begin
        if (a[15:0] == 16'h4) exp = m_status();
        else if (a[15:0] == 16'h8) exp = m_cnt;
      end
    end
    if (known) chk("m_data_o", last_rd, exp);
    chk("m_tx_valid", {31'h0, last_txv}, {31'h0, q.size() != 0});
    chk("m_tx_data", {24'h0, last_txd}, (q.size() != 0) ? {24'h0, q[0]} : 32'h0);
    chk("m_err_o", {31'h0, last_err}, {31'h0, m_err});
    // model update for the coming edge
    set = c && (!al || (!mm && !rm));
    pop = (q.size() != 0) && r;
    push = 0; clr_e = 0; clr_o = 0; ovf_set = 0;
    if (c && w && al && rm) begin
      m_mem[a[11:2]] = d;
      m_known[a[11:2]] = 1;
    end
    if (c && w && al && mm) begin
      if (a[15:0] == 16'h0) push = 1;
      if (a[15:0] == 16'h4) begin clr_e = d[2]; clr_o = d[3]; end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < 8) q.push_back(d[7:0]);
      else ovf_set = 1;
    end
    m_err = (m_err && !clr_e) || set;
    m_ovf = (m_ovf && !clr_o) || ovf_set;
    m_cnt = m_cnt + 1;
    @(negedge clk);
  endtask

  typedef struct {
    logic        ce, we;
    logic [31:0] addr, din, exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tv[18];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c1, c2;
    int k;
    logic [31:0] a;
    tv[0]  = '{1, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0};
    tv[1]  = '{1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
    tv[2]  = '{0, 0, 32'h10, 32'h0, 32'h0, 0};
    tv[3]  = '{1, 1, 32'h12, 32'h12345678, 32'h0, 0};
    tv[4]  = '{1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1};
    tv[5]  = '{1, 0, STS, 32'h0, 32'h5, 1};
    tv[6]  = '{1, 1, STS, 32'h4, 32'h0, 1};
    tv[7]  = '{1, 0, STS, 32'h0, 32'h1, 0};
    tv[8]  = '{1, 0, 32'h4000, 32'h0, 32'h0, 0};
    tv[9]  = '{1, 0, STS, 32'h0, 32'h5, 1};
    tv[10] = '{1, 1, STS, 32'h4, 32'h0, 1};
    tv[11] = '{1, 0, 32'hFFFF_000C, 32'h0, 32'h0, 0};
    tv[12] = '{1, 1, 32'hFFFF_000C, 32'hFF, 32'h0, 0};
    tv[13] = '{1, 0, STS, 32'h0, 32'h1, 0};
    tv[14] = '{1, 0, 32'hFFFF_0002, 32'h0, 32'h0, 0};
    tv[15] = '{1, 0, STS, 32'h0, 32'h5, 1};
    tv[16] = '{1, 1, STS, 32'h4, 32'h0, 1};
    tv[17] = '{1, 0, TXD, 32'h0, 32'h0, 0};

    m_reset();
    @(negedge clk); @(negedge clk);
    #1 chk("reset_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("reset_tx_data", {24'h0, tx_data_o}, 32'h0);
    chk("reset_err", {31'h0, err_o}, 32'h0);
    @(negedge clk);
    rst = 0;
    m_reset();

    // decode, RAM, error sticky and STATUS clear
    for (int i = 0; i < 18; i++) begin
      do_cycle(tv[i].ce, tv[i].we, tv[i].addr, tv[i].din, 1'b0);
      chk($sformatf("vec%0d_rd", i), last_rd, tv[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'h0, last_err}, {31'h0, tv[i].exp_err});
    end

    // fill, overflow, ordered drain
    for (int i = 0; i < 8; i++) do_cycle(1, 1, TXD, 32'h41 + i, 0);
    do_cycle(1, 0, STS, 0, 0);
    chk("full_status", last_rd, 32'h2);
    chk("full_head", {24'h0, last_txd}, 32'h41);
    do_cycle(1, 1, TXD, 32'h49, 0);
    do_cycle(1, 0, STS, 0, 0);
    chk("ovf_status", last_rd, 32'hA);
    for (int i = 0; i < 8; i++) begin
      do_cycle(0, 0, 0, 0, 1);
      chk($sformatf("drain%0d", i), {23'h0, last_txv, last_txd}, {23'h0, 1'b1, 8'h41 + 8'(i)});
    end
    do_cycle(0, 0, 0, 0, 1);
    chk("drain_empty", {31'h0, last_txv}, 32'h0);
    do_cycle(1, 1, STS, 32'h8, 0);
    do_cycle(1, 0, STS, 0, 0);
    chk("ovf_clear", last_rd, 32'h1);

    // full with simultaneous pop and push
    for (int i = 0; i < 8; i++) do_cycle(1, 1, TXD, 32'h61 + i, 0);
    do_cycle(1, 1, TXD, 32'h5A, 1);
    do_cycle(1, 0, STS, 0, 0);
    chk("pushpop_status", last_rd, 32'h2);
    for (int i = 0; i < 8; i++) begin
      do_cycle(0, 0, 0, 0, 1);
      chk($sformatf("pp_drain%0d", i), {24'h0, last_txd}, (i == 7) ? 32'h5A : 32'h62 + i);
    end
    do_cycle(0, 0, 0, 0, 1);
    chk("pp_empty", {31'h0, last_txv}, 32'h0);

    // cycle counter delta and wrap
    do_cycle(1, 0, CYC, 0, 0);
    c1 = last_rd;
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 0);
    do_cycle(1, 0, CYC, 0, 0);
    c2 = last_rd;
    chk("cycle_delta", c2 - c1, 32'd5);
    force dut.cyc_q = 32'hFFFF_FFFE;
    #1 release dut.cyc_q;
    m_cnt = 32'hFFFF_FFFE;
    do_cycle(1, 0, CYC, 0, 0);
    chk("cycle_pre", last_rd, 32'hFFFF_FFFE);
    do_cycle(1, 0, CYC, 0, 0);
    chk("cycle_max", last_rd, 32'hFFFF_FFFF);
    do_cycle(1, 0, CYC, 0, 0);
    chk("cycle_wrap", last_rd, 32'h0);

    // async reset mid-drain
    for (int i = 0; i < 5; i++) do_cycle(1, 1, TXD, 32'h71 + i, 0);
    do_cycle(0, 0, 0, 0, 1);
    do_cycle(0, 0, 0, 0, 1);
    ce = 0; rdy = 1;
    #2 rst = 1;
    #1 chk("rst_async_valid", {31'h0, tx_valid_o}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    m_reset();
    do_cycle(1, 0, STS, 0, 0);
    chk("rst_status", last_rd, 32'h1);

    // randomized traffic against the model
    for (int i = 0; i < 16; i++) do_cycle(1, 1, 32'(i * 4), $urandom, 0);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: a = 32'($urandom_range(0, 15) * 4);
        3:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        4:       a = ($urandom_range(0, 1) != 0) ? 32'h1000 + 32'($urandom_range(0, 255) * 4)
                                                 : 32'h8000_0000;
        5, 6:    a = TXD;
        7:       a = STS;
        8:       a = CYC;
        default: a = 32'hFFFF_0000 + 32'($urandom_range(0, 31));
      endcase
      do_cycle($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), a, $urandom,
               1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_dmem_responder.md
Name: riscv_dmem_responder

Overview:
Responder side of the core's data-memory port. It accepts the core's single-cycle load/store requests (ce, we, addr, store data) and returns load data in the same cycle. Requests decode to one of three regions:
- a word-organised RAM;
- a small MMIO page containing a debug-console transmit FIFO, status/clear registers and a free-running cycle counter;
- unmapped space.

The TX FIFO drains to an external byte consumer through a valid/ready handshake.

Parameters:
RAM_AW, 10, log2 of RAM depth in 32-bit words (RAM spans byte addresses 0 .. 4*2^RAM_AW-1)
FIFO_AW, 3, log2 of TX FIFO depth in bytes (depth 8)
MMIO_BASE, 32'hFFFF_0000, base of MMIO page; match on addr[31:16] only

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
data_ce_i  input  1  request enable from core
data_we_i  input  1  1 = store, 0 = load
data_addr_i  input  32  byte address from core
data_i  input  32  store data from core
data_o  output  32  load data to core, combinational
tx_valid_o  output  1  FIFO head byte valid
tx_ready_i  input  1  consumer accepts head byte
tx_data_o  output  8  FIFO head byte
err_o  output  1  sticky access-error flag

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and count cleared; tx_valid_o=0, tx_data_o=0.
  - Cycle counter=0; overflow and error stickies=0; err_o=0.
  - RAM contents are not cleared.
- Definitions:
  - load = ce & !we.
  - store = ce & we.
  - aligned = addr[1:0]==0.
- Decode:
  - MMIO: addr[31:16]==MMIO_BASE[31:16].
  - RAM: not MMIO and addr < 4*2^RAM_AW.
  - Unmapped: anything else.
- data_o:
  - 0 unless the request is a load.
  - Aligned RAM load: mem[addr[RAM_AW+1:2]], zero latency.
  - Misaligned or unmapped load: 0.
- RAM store: aligned store writes the full word at the rising edge. Read-during-write to the same word returns the old word (combinational read of the pre-edge array).
- Error conditions: misaligned or unmapped access (load or store, when ce=1) sets the error sticky at the edge. The store is dropped.
- MMIO register map (offset = addr[15:0]):
  - 0x0 TXDATA
    - Write pushes data_i[7:0] into the FIFO.
    - Read returns 0.
  - 0x4 STATUS
    - Read: {28'b0, overflow, error, full, empty}.
    - Write: data_i[3]=1 clears overflow; data_i[2]=1 clears error.
    - A set event and a clear in the same cycle leaves the sticky set.
  - 0x8 CYCLE
    - Read returns the counter value.
    - Writes are ignored.
  - Other aligned offsets: reads return 0; writes are ignored with no error.
  - Misaligned MMIO access sets the error sticky.
- Cycle counter: increments by 1 every cycle out of reset; wraps 32'hFFFF_FFFF -> 0.
- TX FIFO:
  - Circular buffer; count occupies FIFO_AW+1 bits.
  - tx_valid_o = (count != 0); tx_data_o = head entry, or 0 when empty.
  - Pop occurs at the edge when tx_valid_o & tx_ready_i.
  - Push is accepted when count < depth, or when a pop occurs in the same cycle (full plus simultaneous pop and push: count unchanged, new byte enters at the tail).
  - Push with FIFO full and no pop: byte dropped, overflow sticky set.
  - Simultaneous push and pop on an empty FIFO cannot occur (no valid head), so this is a push only.
  - Pointers wrap modulo depth.
  - full = (count == depth); empty = (count == 0).
- Reset mid-operation: FIFO contents are discarded immediately and tx_valid_o drops asynchronously. The core side has no pending state.

Test Plan:
1. Store 32'hDEADBEEF to 0x0000_0010, then load 0x10 → data_o=32'hDEADBEEF in the load cycle. A load with ce=0 → data_o=0.
2. Store 32'h12345678 to 0x0000_0012 (misaligned) → RAM word at 0x10 unchanged, err_o=1 next cycle, STATUS reads 4'b0101 (error set, FIFO empty). Write 32'h4 to STATUS → err_o=0.
3. With tx_ready_i=0, push 9 bytes 0x41..0x49 to TXDATA:
   - after 8 pushes STATUS=4'b0010 (full);
   - the 9th push is dropped and STATUS=4'b1010 (overflow set).
   - Then raise tx_ready_i → bytes 0x41..0x48 emerge in order, one per cycle, then tx_valid_o=0.
4. FIFO full, tx_ready_i=1, push 0x5A in the same cycle → no overflow, count stays 8, and 0x5A is the last byte drained.
5. Load CYCLE twice, 5 cycles apart → difference is 5. Force the counter near 32'hFFFF_FFFE → it wraps to 0 after 2 cycles.
6. Assert rst asynchronously mid-drain with 3 bytes queued → tx_valid_o=0 immediately, and STATUS=4'b0001 after release.
